// File: rtl/tpram_burst_reader_pkg.sv
// Shared types and helpers for the two-port RAM read initiator.
// Holds the burst FSM encoding and the address-width helper.
package tpram_burst_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } rd_state_t;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/tpram_rd_fifo.sv
// Small synchronous FIFO holding {last, data} read words.
// Output is forced to zero while empty so idle outputs are clean.
module tpram_rd_fifo #(
  parameter  int W  = 33,
  parameter  int D  = 2,
  localparam int CW = $clog2(D + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  logic [W-1:0]  mem [D];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(D - 1)) ? '0 : p + 1'b1;
  endfunction

  // storage write, no reset needed
  always_ff @(posedge clock) begin
    if (push) mem[wp] <= din;
  end

  // pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= nxt(wp);
      if (pop)  rp <= nxt(rp);
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  assign empty = (count == '0);
  assign dout  = empty ? '0 : mem[rp];

endmodule

// File: rtl/tpram_burst_reader.sv
// Burst read initiator for RAM port A with credit-based issue.
// Streams words out as valid/ready with a last flag.
module tpram_burst_reader
  import tpram_burst_reader_pkg::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int DEPTH      = 1024,
  parameter  int LEN_WIDTH  = 11,
  parameter  int FIFO_DEPTH = 2,
  localparam int AW         = addr_w(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [AW-1:0]         cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  CENA,
  output logic [AW-1:0]         AA,
  input  logic [DATA_WIDTH-1:0] QA
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  rd_state_t             state;
  rd_state_t             state_nx;
  logic [AW-1:0]         addr;
  logic [LEN_WIDTH-1:0]  rem;
  logic                  infl;
  logic                  infl_last;
  logic [CW-1:0]         fcnt;
  logic                  fempty;
  logic [DATA_WIDTH:0]   fdout;
  logic                  pop;
  logic                  issue;
  logic                  start;
  logic                  is_last;
  logic [CW:0]           occ;

  function automatic logic [AW-1:0] nxt_addr(
    input logic [AW-1:0] a
  );
    return (a == AW'(DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign pop     = out_valid & out_ready;
  assign is_last = (rem == LEN_WIDTH'(1));
  assign occ     = (CW+1)'(fcnt)
                 + (CW+1)'(infl)
                 - (CW+1)'(pop);
  assign issue   = (state == ISSUE)
                && (occ < (CW+1)'(FIFO_DEPTH));

  // next-state and command handshake
  always_comb begin
    state_nx  = state;
    cmd_ready = 1'b0;
    start     = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_len != '0) begin
          start    = 1'b1;
          state_nx = ISSUE;
        end
      end
      ISSUE: begin
        if (issue && is_last) state_nx = DRAIN;
      end
      DRAIN: begin
        if (!infl && fempty) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // address and remaining-length counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr <= '0;
      rem  <= '0;
    end else if (start) begin
      addr <= cmd_addr;
      rem  <= cmd_len;
    end else if (issue) begin
      addr <= nxt_addr(addr);
      rem  <= rem - 1'b1;
    end
  end

  // one-cycle read latency tracker with last tag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      infl      <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      infl      <= issue;
      infl_last <= issue & is_last;
    end
  end

  tpram_rd_fifo #(
    .W (DATA_WIDTH + 1),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (infl),
    .din   ({infl_last, QA}),
    .pop   (pop),
    .dout  (fdout),
    .empty (fempty),
    .count (fcnt)
  );

  assign busy      = (state != IDLE);
  assign CENA      = ~issue;
  assign AA        = addr;
  assign out_valid = ~fempty;
  assign out_data  = fdout[DATA_WIDTH-1:0];
  assign out_last  = fdout[DATA_WIDTH];

endmodule
